// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue for the MIPS32 IF stage: issues sequential word
// reads, buffers returned words with their next-PC, and flushes on redirect.
module mips32_fetch_queue #(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [31:0]            mem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_ir,
  output logic [31:0]            out_npc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_pend_pc;
  logic              r_pend;
  logic [31:0]       r_ir  [DEPTH];
  logic [ADDR_W-1:0] r_npc [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_count;

  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [SW-1:0]     w_committed;

  // An in-flight read already owns a slot, so it is counted against capacity;
  // a same-cycle pop is deliberately not credited.
  always_comb begin
    w_committed = SW'(r_count) + SW'(r_pend);
    w_issue     = !reset && !halt && !redirect && (w_committed < SW'(DEPTH));
    w_push      = r_pend && !redirect;
    w_pop       = out_valid && out_ready && !redirect;
  end

  assign mem_rd    = w_issue;
  assign mem_addr  = r_fpc;
  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign out_ir    = out_valid ? r_ir[r_rp] : '0;
  assign out_npc   = out_valid ? 32'(r_npc[r_rp]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc     <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
    end else if (redirect) begin
      r_fpc   <= redirect_pc;
      r_pend  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_fpc     <= r_fpc + ADDR_W'(1);
        r_pend_pc <= r_fpc;
      end
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_ir[r_wp]  <= mem_rdata;
      r_npc[r_wp] <= r_pend_pc + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue with a one-cycle-latency memory model
// where mem[i] = 0x1000_0000 + i.
module tb_mips32_fetch_queue;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_ir;
  logic [31:0]       out_npc;
  logic [CW-1:0]     count;
  logic              tb_pend = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips32_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(10'h000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ir     (out_ir),
    .out_npc    (out_npc),
    .count      (count)
  );

  always @(posedge clk) if (mem_rd) mem_rdata <= BASE + 32'(mem_addr);
  always @(posedge clk) tb_pend <= (reset || redirect) ? 1'b0 : mem_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // A returning word must never land in a full queue.
  always @(negedge clk)
    if (tb_pend && !reset && !redirect)
      check("no_overflow", 32'(count == CW'(DEPTH)), 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    32'(mem_rd),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ir"},    out_ir,         32'd0);
    check({tag, "_npc"},   out_npc,        32'd0);
    check({tag, "_count"}, 32'(count),     32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    halt = 1'b0;
    step();
    settle();
    check_reset_outputs("rst");
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Stream with out_ready held high
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      settle();
      check("s_rd", 32'(mem_rd), 32'd1);
      check("s_addr", 32'(mem_addr), 32'(c));
      if (c < 2) begin
        check("s_valid0", 32'(out_valid), 32'd0);
      end else begin
        check("s_valid", 32'(out_valid), 32'd1);
        check("s_ir", out_ir, BASE + 32'(c - 2));
        check("s_npc", out_npc, 32'(c - 1));
        check("s_count", 32'(count), 32'd1);
      end
      step();
    end

    // Backpressure, then release
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 6);
      settle();
      if (c <= 3) begin
        check("bp_rd", 32'(mem_rd), 32'd1);
        check("bp_addr", 32'(mem_addr), 32'(c));
      end
      if (c >= 4 && c <= 6) check("bp_stop", 32'(mem_rd), 32'd0);
      if (c == 5) check("bp_full", 32'(count), 32'(DEPTH));
      if (c == 7) check("bp_resume", 32'(mem_addr), 32'd4);
      if (c >= 5) begin
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_ir", out_ir, BASE + 32'((c < 6) ? 0 : c - 6));
      end
      step();
    end

    // Redirect with a read pending, coincident pop, wrap, halt, mid-run reset
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      redirect    = (c == 4) || (c == 10) || (c == 15);
      redirect_pc = (c == 4) ? 10'h020 : (c == 10) ? 10'h100 : 10'h3FF;
      out_ready   = (c >= 8);
      halt        = (c >= 20 && c <= 23);
      reset       = (c == 27 || c == 28);
      settle();
      case (c)
        4: begin
          check("rd_noread", 32'(mem_rd), 32'd0);
          check("rd_cnt_pre", 32'(count), 32'd3);
        end
        5: begin
          check("rd_flush_cnt", 32'(count), 32'd0);
          check("rd_flush_valid", 32'(out_valid), 32'd0);
          check("rd_tgt_rd", 32'(mem_rd), 32'd1);
          check("rd_tgt_addr", 32'(mem_addr), 32'h020);
        end
        6: begin
          check("rd_valid_t2", 32'(out_valid), 32'd0);
          check("rd_addr_t2", 32'(mem_addr), 32'h021);
        end
        7, 8: begin
          check("rd_tgt_valid", 32'(out_valid), 32'd1);
          check("rd_tgt_ir", out_ir, BASE + 32'h020);
          check("rd_tgt_npc", out_npc, 32'h021);
        end
        9: check("rd_next_ir", out_ir, BASE + 32'h021);
        10: begin
          check("pop_valid", 32'(out_valid), 32'd1);
          check("pop_ir", out_ir, BASE + 32'h022);
        end
        11: begin
          check("pop_flush_cnt", 32'(count), 32'd0);
          check("pop_flush_valid", 32'(out_valid), 32'd0);
          check("pop_tgt_addr", 32'(mem_addr), 32'h100);
        end
        12: check("pop_valid_t2", 32'(out_valid), 32'd0);
        13: begin
          check("pop_tgt_ir", out_ir, BASE + 32'h100);
          check("pop_tgt_npc", out_npc, 32'h101);
        end
        14: check("pop_next_ir", out_ir, BASE + 32'h101);
        16: check("wrap_addr", 32'(mem_addr), 32'h3FF);
        17: check("wrap_addr0", 32'(mem_addr), 32'h000);
        18: begin
          check("wrap_ir", out_ir, BASE + 32'h3FF);
          check("wrap_npc", out_npc, 32'h000);
        end
        19: begin
          check("wrap_ir0", out_ir, BASE);
          check("wrap_npc0", out_npc, 32'h001);
        end
        20: begin
          check("halt_rd", 32'(mem_rd), 32'd0);
          check("halt_ir1", out_ir, BASE + 32'h001);
          check("halt_npc1", out_npc, 32'h002);
        end
        21: begin
          check("halt_rd2", 32'(mem_rd), 32'd0);
          check("halt_pend_ir", out_ir, BASE + 32'h002);
          check("halt_cnt1", 32'(count), 32'd1);
        end
        22, 23: begin
          check("halt_drain_cnt", 32'(count), 32'd0);
          check("halt_drain_valid", 32'(out_valid), 32'd0);
          check("halt_drain_ir", out_ir, 32'd0);
          check("halt_drain_npc", out_npc, 32'd0);
          check("halt_rd3", 32'(mem_rd), 32'd0);
        end
        24: begin
          check("resume_rd", 32'(mem_rd), 32'd1);
          check("resume_addr", 32'(mem_addr), 32'h003);
        end
        25: check("resume_addr2", 32'(mem_addr), 32'h004);
        26: begin
          check("resume_ir", out_ir, BASE + 32'h003);
          check("resume_npc", out_npc, 32'h004);
        end
        28: check_reset_outputs("midrst");
        29: begin
          check("post_rst_rd", 32'(mem_rd), 32'd1);
          check("post_rst_addr", 32'(mem_addr), 32'h000);
          check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        31: begin
          check("post_rst_ir", out_ir, BASE);
          check("post_rst_npc", out_npc, 32'h001);
        end
        default: ;
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
